xref_symbol_resolver: RTL

- Hardware cross-reference stage. Sits directly downstream of the identifier/declaration extraction stage that emits package, function and variable symbols with their enclosing scopes.
- Stores each symbol definition in a small scoped table, then resolves later references to a definition slot index.
- Closing a scope releases that scope's definitions.
- Emits one resolution record per accepted request, giving the "defines/binding" or "ref" fact for the downstream indexer.

---
 rtl/xref_symbol_resolver.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/xref_symbol_resolver.sv
// xref_symbol_resolver: scoped symbol table for the cross-reference stage.
// Each request (DEF / REF / CLOSE) scans the DEPTH-entry table one entry per
// cycle, then presents one resolution record until it is consumed.
// Optional build macro: XREF_RESOLVER_STATS_EN adds saturating counters for
// resolved / unresolved references.
module xref_symbol_resolver #(
    parameter int HASH_W  = 16,
    parameter int SCOPE_W = 4,
    parameter int DEPTH   = 8,
    parameter int IDX_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [HASH_W-1:0]  in_hash,
    input  logic [SCOPE_W-1:0] in_scope,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_op,
    output logic [1:0]         out_status,
    output logic [IDX_W-1:0]   out_idx,
    output logic [IDX_W:0]     occupancy
`ifdef XREF_RESOLVER_STATS_EN
    ,
    output logic [15:0]        stat_resolved,
    output logic [15:0]        stat_unresolved
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_t;

    localparam logic [1:0] OP_DEF  = 2'd0;
    localparam logic [1:0] OP_REF  = 2'd1;
    localparam logic [1:0] ST_NEW  = 2'd0;
    localparam logic [1:0] ST_DUP  = 2'd1;
    localparam logic [1:0] ST_RES  = 2'd2;
    localparam logic [1:0] ST_MISS = 2'd3;

    state_t               state_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [1:0]           op_q;
    logic [HASH_W-1:0]    hash_q;
    logic [SCOPE_W-1:0]   scope_q;

    // scan bookkeeping
    logic                 lhit_q, lhit_d, ghit_q, ghit_d, ffound_q, ffound_d;
    logic [IDX_W-1:0]     lidx_q, lidx_d, gidx_q, gidx_d, fidx_q, fidx_d;

    // table
    logic [DEPTH-1:0]     valid_q;
    logic [HASH_W-1:0]    hash_tab_q  [DEPTH];
    logic [SCOPE_W-1:0]   scope_tab_q [DEPTH];

    logic                 in_ready_q, out_valid_q;
    logic [1:0]           out_op_q, out_status_q;
    logic [IDX_W-1:0]     out_idx_q;
    logic [IDX_W:0]       occ_q, pop;
    logic                 last_scan, ins_en;

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_op     = out_op_q;
    assign out_status = out_status_q;
    assign out_idx    = out_idx_q;
    assign occupancy  = occ_q;

    assign last_scan = (state_q == S_SCAN) && (ptr_q == IDX_W'(DEPTH - 1));
    // insert on the final scan edge, once the whole table has been seen
    assign ins_en    = last_scan && (op_q == OP_DEF) && !lhit_d && ffound_d;

    // fold entry[ptr] into the running scan results (first match / first free wins)
    always_comb begin
        lhit_d   = lhit_q;   lidx_d = lidx_q;
        ghit_d   = ghit_q;   gidx_d = gidx_q;
        ffound_d = ffound_q; fidx_d = fidx_q;
        if (valid_q[ptr_q] && hash_tab_q[ptr_q] == hash_q) begin
            if (!lhit_q && scope_tab_q[ptr_q] == scope_q) begin
                lhit_d = 1'b1;
                lidx_d = ptr_q;
            end
            if (!ghit_q && scope_tab_q[ptr_q] == '0) begin
                ghit_d = 1'b1;
                gidx_d = ptr_q;
            end
        end
        if (!ffound_q && !valid_q[ptr_q]) begin
            ffound_d = 1'b1;
            fidx_d   = ptr_q;
        end
    end

    // population count of the valid bits, registered as occupancy
    always_comb begin
        pop = '0;
        for (int i = 0; i < DEPTH; i++) pop = pop + {{IDX_W{1'b0}}, valid_q[i]};
    end

    // hash/scope payload needs no reset: it is only meaningful under valid_q
    always_ff @(posedge clk) begin
        if (!rst && ins_en) begin
            hash_tab_q[fidx_d]  <= hash_q;
            scope_tab_q[fidx_d] <= scope_q;
        end
    end

    // request FSM: IDLE accepts, SCAN walks the table, RESP holds the record
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            op_q         <= '0;
            hash_q       <= '0;
            scope_q      <= '0;
            {lhit_q, ghit_q, ffound_q} <= '0;
            {lidx_q, gidx_q, fidx_q}   <= '0;
            valid_q      <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_op_q     <= '0;
            out_status_q <= '0;
            out_idx_q    <= '0;
            occ_q        <= '0;
        end else begin
            occ_q <= pop;
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        op_q       <= in_op;
                        hash_q     <= in_hash;
                        scope_q    <= in_scope;
                        {lhit_q, ghit_q, ffound_q} <= '0;
                        {lidx_q, gidx_q, fidx_q}   <= '0;
                        ptr_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    {lhit_q, ghit_q, ffound_q} <= {lhit_d, ghit_d, ffound_d};
                    {lidx_q, gidx_q, fidx_q}   <= {lidx_d, gidx_d, fidx_d};
                    // CLOSE (and reserved op 3) drops matching-scope entries as they pass
                    if (op_q[1] && scope_tab_q[ptr_q] == scope_q) valid_q[ptr_q] <= 1'b0;
                    if (ins_en) valid_q[fidx_d] <= 1'b1;
                    if (last_scan) state_q <= S_RESP;
                    else           ptr_q   <= ptr_q + IDX_W'(1);
                end
                S_RESP: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_op_q    <= op_q;
                        if (op_q == OP_DEF) begin
                            if (lhit_q) begin
                                out_status_q <= ST_DUP; out_idx_q <= lidx_q;
                            end else if (ffound_q) begin
                                out_status_q <= ST_NEW; out_idx_q <= fidx_q;
                            end else begin
                                out_status_q <= ST_MISS; out_idx_q <= '0;
                            end
                        end else if (op_q == OP_REF) begin
                            if (lhit_q) begin
                                out_status_q <= ST_RES; out_idx_q <= lidx_q;
                            end else if (ghit_q) begin
                                out_status_q <= ST_RES; out_idx_q <= gidx_q;
                            end else begin
                                out_status_q <= ST_MISS; out_idx_q <= '0;
                            end
                        end else begin
                            out_status_q <= ST_NEW; out_idx_q <= '0;
                        end
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef XREF_RESOLVER_STATS_EN
    logic [15:0] stat_res_q, stat_unres_q;
    assign stat_resolved   = stat_res_q;
    assign stat_unresolved = stat_unres_q;

    // count REF outcomes on the response handshake, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_res_q   <= '0;
            stat_unres_q <= '0;
        end else if (state_q == S_RESP && out_valid_q && out_ready && out_op_q == OP_REF) begin
            if (out_status_q == ST_RES && stat_res_q != 16'hFFFF)
                stat_res_q <= stat_res_q + 16'd1;
            if (out_status_q == ST_MISS && stat_unres_q != 16'hFFFF)
                stat_unres_q <= stat_unres_q + 16'd1;
        end
    end
`endif

endmodule
